// File: rtl/fmap_tile_reader_pkg.sv
// Shared constants, FSM encodings and config type for the feature-map tile reader.
package fmap_tile_reader_pkg;

  localparam int ADDR_W = 12;
  localparam int WORD_W = 32;
  localparam int DIM_W  = 7;
  localparam int FIFO_D = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [DIM_W-1:0]  rows;
    logic [DIM_W-1:0]  cols;
    logic [DIM_W-1:0]  pitch;
  } tile_cfg_t;

endpackage

// File: rtl/fmap_tile_reader_fifo.sv
// Show-ahead synchronous FIFO; simultaneous push and pop are both honoured.
module fmap_tile_reader_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH-1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  // Handshake qualification against occupancy
  always_comb begin
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign empty    = (count_r == {CW{1'b0}});
  assign count    = count_r;

endmodule

// File: rtl/fmap_tile_reader.sv
// Walks a rows x cols tile in the feature-map RAM and streams the words out over
// valid/ready, absorbing the RAM's one-cycle read latency with a credit-checked FIFO.
module fmap_tile_reader
  import fmap_tile_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int WIDTH      = WORD_W,
  parameter int DIM_WIDTH  = DIM_W,
  parameter int FIFO_DEPTH = FIFO_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  rows,
  input  logic [DIM_WIDTH-1:0]  cols,
  input  logic [DIM_WIDTH-1:0]  pitch,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [WIDTH-1:0]      ram_data,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [DIM_WIDTH-1:0] DIM_ZERO = {DIM_WIDTH{1'b0}};
  localparam logic [DIM_WIDTH-1:0] DIM_ONE  = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW:0]          DEPTH_L  = (CW+1)'(FIFO_DEPTH);
  localparam int                   EXT_W    = ADDR_WIDTH - DIM_WIDTH;

  logic [1:0]            state_r, state_s;
  logic [DIM_WIDTH-1:0]  rows_r, cols_r, pitch_r;
  logic [DIM_WIDTH-1:0]  r_r, c_r;
  logic [ADDR_WIDTH-1:0] row_base_r;
  logic                  inflight_r, last_tag_r;
  logic                  busy_r, done_r;
  logic                  issue_s, final_s, col_end_s, credit_s, empty_tile_s;
  logic [CW-1:0]         fifo_count_s;
  logic                  fifo_empty_s;
  logic                  pop_s;
  logic [WIDTH:0]        fifo_dout_s;

  // Issue qualification: a read is only launched if the FIFO can absorb it
  always_comb begin
    empty_tile_s = (rows == DIM_ZERO) || (cols == DIM_ZERO);
    col_end_s    = (c_r == cols_r - DIM_ONE);
    final_s      = col_end_s && (r_r == rows_r - DIM_ONE);
    credit_s     = ({1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_r}) < DEPTH_L;
    issue_s      = (state_r == ST_ISSUE) && credit_s;
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (empty_tile_s) state_s = ST_FINISH;
          else              state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_s && final_s) state_s = ST_DRAIN;
        else                    state_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (fifo_empty_s && !inflight_r) state_s = ST_FINISH;
        else                             state_s = ST_DRAIN;
      end
      ST_FINISH: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // FSM, tile counters and read-pipeline tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rows_r     <= DIM_ZERO;
      cols_r     <= DIM_ZERO;
      pitch_r    <= DIM_ZERO;
      r_r        <= DIM_ZERO;
      c_r        <= DIM_ZERO;
      row_base_r <= {ADDR_WIDTH{1'b0}};
      inflight_r <= 1'b0;
      last_tag_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_FINISH);
      inflight_r <= issue_s;
      last_tag_r <= issue_s && final_s;
      if ((state_r == ST_IDLE) && start) begin
        rows_r     <= rows;
        cols_r     <= cols;
        pitch_r    <= pitch;
        r_r        <= DIM_ZERO;
        c_r        <= DIM_ZERO;
        row_base_r <= base_addr;
      end else if (issue_s) begin
        if (col_end_s) begin
          c_r        <= DIM_ZERO;
          r_r        <= r_r + DIM_ONE;
          row_base_r <= row_base_r + {{EXT_W{1'b0}}, pitch_r};
        end else begin
          c_r <= c_r + DIM_ONE;
        end
      end
    end
  end

  // RAM address is parked at zero whenever no tile is being walked
  always_comb begin
    if (state_r == ST_ISSUE) begin
      ram_addr = row_base_r + {{EXT_W{1'b0}}, c_r};
    end else begin
      ram_addr = {ADDR_WIDTH{1'b0}};
    end
  end

  assign pop_s = out_valid && out_ready;

  fmap_tile_reader_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data ({last_tag_r, ram_data}),
    .pop       (pop_s),
    .pop_data  (fifo_dout_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign ram_we    = 1'b0;
  assign out_valid = ~fifo_empty_s;
  assign out_data  = fifo_dout_s[WIDTH-1:0];
  assign out_last  = fifo_dout_s[WIDTH] & ~fifo_empty_s;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
